// File: rtl/cpu_pkg.sv
// Shared definitions for the RISC CPU sequencing controller: state
// encoding, opcode values and the ALU-opcode classifier.
package cpu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_S0   = 4'd1,
    ST_S1   = 4'd2,
    ST_S2   = 4'd3,
    ST_S3   = 4'd4,
    ST_S4   = 4'd5,
    ST_S5   = 4'd6,
    ST_S6   = 4'd7,
    ST_S7   = 4'd8,
    ST_HALT = 4'd9
  } state_e;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // Opcodes that read an operand from memory and write the accumulator.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_seq_ctrl.sv
// Instruction-sequencing controller: walks each instruction through an
// 8-clock fetch/execute cycle and issues registered control strobes.
// Optional feature macro: CPU_SEQ_SINGLE_STEP_EN adds step_mode/step inputs
// that gate every start of an instruction on a one-cycle step pulse.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int ICNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic [2:0]        opcode,
  input  logic              zero,
`ifdef CPU_SEQ_SINGLE_STEP_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  output logic              fetch,
  output logic              rd,
  output logic              wr,
  output logic              load_ir,
  output logic              inc_pc,
  output logic              load_pc,
  output logic              load_acc,
  output logic              datactl_ena,
  output logic              halt,
  output logic [3:0]        state,
  output logic [ICNT_W-1:0] icount
);

  state_e              state_q, state_d;
  logic                fetch_q, fetch_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                load_ir_q, load_ir_d;
  logic                inc_pc_q, inc_pc_d;
  logic                load_pc_q, load_pc_d;
  logic                load_acc_q, load_acc_d;
  logic                datactl_q, datactl_d;
  logic                halt_q, halt_d;
  logic [ICNT_W-1:0]   icount_q;
  logic                advance;
  logic                alu_op;
  logic                skz_taken;

  // A new instruction may start only when run is enabled (and, in single-step builds, a step pulse is present).
  always_comb begin
`ifdef CPU_SEQ_SINGLE_STEP_EN
    advance = ena && (!step_mode || step);
`else
    advance = ena;
`endif
  end

  // Next-state sequencing; HALT is sticky until reset, S7 decides between the next fetch and IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (advance) state_d = ST_S0;
      ST_S0:   state_d = ST_S1;
      ST_S1:   state_d = ST_S2;
      ST_S2:   state_d = ST_S3;
      ST_S3:   state_d = (opcode == OP_HLT) ? ST_HALT : ST_S4;
      ST_S4:   state_d = ST_S5;
      ST_S5:   state_d = ST_S6;
      ST_S6:   state_d = ST_S7;
      ST_S7:   state_d = advance ? ST_S0 : ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the state being entered so they register alongside it.
  always_comb begin
    alu_op     = is_alu_op(opcode);
    skz_taken  = (opcode == OP_SKZ) && zero;
    fetch_d    = 1'b0;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    load_ir_d  = 1'b0;
    inc_pc_d   = 1'b0;
    load_pc_d  = 1'b0;
    load_acc_d = 1'b0;
    datactl_d  = 1'b0;
    halt_d     = 1'b0;
    case (state_d)
      ST_S0, ST_S1: begin
        fetch_d   = 1'b1;
        rd_d      = 1'b1;
        load_ir_d = 1'b1;
        inc_pc_d  = 1'b1;
      end
      ST_S2: fetch_d = 1'b1;
      ST_S3: begin
        fetch_d = 1'b1;
        halt_d  = (opcode == OP_HLT);
      end
      ST_S4: begin
        load_pc_d = (opcode == OP_JMP);
        rd_d      = alu_op;
        datactl_d = (opcode == OP_STO);
      end
      ST_S5: begin
        rd_d       = alu_op;
        load_acc_d = alu_op;
        wr_d       = (opcode == OP_STO);
        datactl_d  = (opcode == OP_STO);
        inc_pc_d   = skz_taken;
      end
      ST_S6: datactl_d = (opcode == OP_STO);
      ST_S7: inc_pc_d = skz_taken;
      ST_HALT: halt_d = 1'b1;
      default: ;
    endcase
  end

  // State and strobe registers; reset clears every strobe immediately, even mid-store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      fetch_q    <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      load_ir_q  <= 1'b0;
      inc_pc_q   <= 1'b0;
      load_pc_q  <= 1'b0;
      load_acc_q <= 1'b0;
      datactl_q  <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_q    <= fetch_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      load_ir_q  <= load_ir_d;
      inc_pc_q   <= inc_pc_d;
      load_pc_q  <= load_pc_d;
      load_acc_q <= load_acc_d;
      datactl_q  <= datactl_d;
      halt_q     <= halt_d;
    end
  end

  // Retired-instruction counter: bumps as each instruction leaves S7 and wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      icount_q <= '0;
    end else if (state_q == ST_S7) begin
      icount_q <= icount_q + ICNT_W'(1);
    end
  end

  assign fetch       = fetch_q;
  assign rd          = rd_q;
  assign wr          = wr_q;
  assign load_ir     = load_ir_q;
  assign inc_pc      = inc_pc_q;
  assign load_pc     = load_pc_q;
  assign load_acc    = load_acc_q;
  assign datactl_ena = datactl_q;
  assign halt        = halt_q;
  assign state       = state_q;
  assign icount      = icount_q;

endmodule
